// File: rtl/bcd_digit_adder.sv
// -----------------------------------------------------------------------------
// bcd_digit_adder
//   Registered packed-BCD adder. Adds two NUM_DIGITS-digit 8421-BCD operands
//   plus a carry-in, rippling the decimal carry across all digits in one
//   cycle. Sum, carry-out and an invalid-digit flag are registered, so a
//   result appears one cycle after its inputs are sampled.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   A/B/Cin valid this cycle
//   A, B       in   packed BCD addends, digit 0 in bits [3:0]
//   Cin        in   decimal carry into digit 0
//   out_valid  out  S/Cout/err hold a result from a valid input
//   S          out  packed BCD sum
//   Cout       out  decimal carry out of the most significant digit
//   err        out  some sampled A or B digit was greater than 9
// -----------------------------------------------------------------------------
module bcd_digit_adder #(
   parameter int unsigned NUM_DIGITS = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [4*NUM_DIGITS-1:0]   A,
   input  logic [4*NUM_DIGITS-1:0]   B,
   input  logic                      Cin,
   output logic                      out_valid,
   output logic [4*NUM_DIGITS-1:0]   S,
   output logic                      Cout,
   output logic                      err
);

   logic [4*NUM_DIGITS-1:0] w_sum;
   logic                    w_cout;
   logic                    w_err;
   logic [4:0]              w_t;
   logic                    w_c;
   logic [3:0]              w_a_dig;
   logic [3:0]              w_b_dig;

   logic                    r_valid;
   logic [4*NUM_DIGITS-1:0] r_sum;
   logic                    r_cout;
   logic                    r_err;

   // Ripple decimal carry through all digits. Invalid digits still go
   // through the same correction; only the err flag reports them.
   always_comb begin
      w_sum   = '0;
      w_err   = 1'b0;
      w_c     = Cin;
      w_t     = '0;
      w_a_dig = '0;
      w_b_dig = '0;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         w_a_dig = A[4*i +: 4];
         w_b_dig = B[4*i +: 4];
         w_t     = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'b0000, w_c};
         if (w_t > 5'd9) begin
            w_sum[4*i +: 4] = w_t[3:0] + 4'd6;  // wraps mod 16
            w_c             = 1'b1;
         end else begin
            w_sum[4*i +: 4] = w_t[3:0];
            w_c             = 1'b0;
         end
         if ((w_a_dig > 4'd9) || (w_b_dig > 4'd9)) begin
            w_err = 1'b1;
         end
      end
      w_cout = w_c;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
            r_err  <= w_err;
         end
      end
   end

   assign out_valid = r_valid;
   assign S         = r_sum;
   assign Cout      = r_cout;
   assign err       = r_err;

endmodule

// File: tb/tb_bcd_digit_adder.sv
// -----------------------------------------------------------------------------
// tb_bcd_digit_adder
//   Drives a 1-digit and a 2-digit adder with the same stimulus and compares
//   every cycle against a digit-by-digit decimal reference model.
// -----------------------------------------------------------------------------
module tb_bcd_digit_adder;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;

   logic       ov1, co1, er1;
   logic [3:0] s1;
   logic       ov2, co2, er2;
   logic [7:0] s2;

   int n_checks;
   int n_fail;

   // Model state: what each DUT's registers should hold.
   logic       e_ov;
   logic [3:0] e_s1;
   logic       e_co1, e_er1;
   logic [7:0] e_s2;
   logic       e_co2, e_er2;

   bcd_digit_adder #(.NUM_DIGITS(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (a[3:0]),
      .B         (b[3:0]),
      .Cin       (cin),
      .out_valid (ov1),
      .S         (s1),
      .Cout      (co1),
      .err       (er1)
   );

   bcd_digit_adder #(.NUM_DIGITS(2)) u_dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .A         (a),
      .B         (b),
      .Cin       (cin),
      .out_valid (ov2),
      .S         (s2),
      .Cout      (co2),
      .err       (er2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Decimal addition digit by digit, as an integer sum with carry.
   function automatic void ref_add(input logic [7:0] x, input logic [7:0] y, input logic c_in,
                                   input int nd, output logic [7:0] s, output logic co,
                                   output logic e);
      int carry;
      int t;
      int xd;
      int yd;
      s     = '0;
      e     = 1'b0;
      carry = int'(c_in);
      for (int i = 0; i < nd; i++) begin
         xd = int'(x >> (4 * i)) % 16;
         yd = int'(y >> (4 * i)) % 16;
         if (xd > 9 || yd > 9) e = 1'b1;
         t = xd + yd + carry;
         if (t > 9) begin
            s     = s | 8'(((t + 6) % 16) << (4 * i));
            carry = 1;
         end else begin
            s     = s | 8'(t << (4 * i));
            carry = 0;
         end
      end
      co = carry[0];
   endfunction

   task automatic check_all(input string tag);
      check_val({tag, "_ov1"}, 32'(ov1), 32'(e_ov));
      check_val({tag, "_s1"},  32'(s1),  32'(e_s1));
      check_val({tag, "_co1"}, 32'(co1), 32'(e_co1));
      check_val({tag, "_er1"}, 32'(er1), 32'(e_er1));
      check_val({tag, "_ov2"}, 32'(ov2), 32'(e_ov));
      check_val({tag, "_s2"},  32'(s2),  32'(e_s2));
      check_val({tag, "_co2"}, 32'(co2), 32'(e_co2));
      check_val({tag, "_er2"}, 32'(er2), 32'(e_er2));
   endtask

   // Apply one cycle of stimulus, update the model, check outputs after the edge.
   task automatic step(input logic v, input logic [7:0] x, input logic [7:0] y, input logic c,
                       input string tag);
      logic [7:0] ts;
      logic       tco, te;
      @(negedge clk);
      in_valid = v;
      a        = x;
      b        = y;
      cin      = c;
      @(posedge clk);
      #1;
      e_ov = v;
      if (v) begin
         ref_add(x, y, c, 1, ts, tco, te);
         e_s1  = ts[3:0];
         e_co1 = tco;
         e_er1 = te;
         ref_add(x, y, c, 2, ts, tco, te);
         e_s2  = ts;
         e_co2 = tco;
         e_er2 = te;
      end
      check_all(tag);
   endtask

   task automatic model_reset();
      e_ov  = 1'b0;
      e_s1  = '0;
      e_co1 = 1'b0;
      e_er1 = 1'b0;
      e_s2  = '0;
      e_co2 = 1'b0;
      e_er2 = 1'b0;
   endtask

   function automatic logic [3:0] rand_digit();
      if ($urandom_range(7, 0) == 0) return 4'($urandom_range(15, 10));
      return 4'($urandom_range(9, 0));
   endfunction

   initial begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [3:0] held_s1;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      cin      = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Single-digit examples
      step(1'b1, 8'h04, 8'h06, 1'b0, "d4p6");
      check_val("d4p6_s_const", 32'(s1), 32'h0);
      check_val("d4p6_co_const", 32'(co1), 32'h1);
      step(1'b1, 8'h09, 8'h09, 1'b0, "d9p9");
      check_val("d9p9_s_const", 32'(s1), 32'h8);
      step(1'b1, 8'h09, 8'h09, 1'b1, "d9p9c");
      check_val("d9p9c_s_const", 32'(s1), 32'h9);
      check_val("d9p9c_co_const", 32'(co1), 32'h1);
      // Back-to-back
      step(1'b1, 8'h01, 8'h04, 1'b0, "b2b0");
      check_val("b2b0_s_const", 32'(s1), 32'h5);
      step(1'b1, 8'h05, 8'h08, 1'b0, "b2b1");
      check_val("b2b1_s_const", 32'(s1), 32'h3);
      check_val("b2b1_co_const", 32'(co1), 32'h1);
      step(1'b1, 8'h00, 8'h00, 1'b0, "b2b2");
      check_val("b2b2_co_const", 32'(co1), 32'h0);
      // Invalid digit
      step(1'b1, 8'h0A, 8'h00, 1'b0, "inv");
      check_val("inv_err_const", 32'(er1), 32'h1);
      check_val("inv_s_const", 32'(s1), 32'h0);
      check_val("inv_co_const", 32'(co1), 32'h1);
      step(1'b1, 8'h02, 8'h03, 1'b0, "inv_clr");
      check_val("inv_clr_err_const", 32'(er1), 32'h0);
      check_val("inv_clr_s_const", 32'(s1), 32'h5);
      // Two-digit examples
      step(1'b1, 8'h99, 8'h01, 1'b0, "w99p01");
      check_val("w99p01_s_const", 32'(s2), 32'h00);
      check_val("w99p01_co_const", 32'(co2), 32'h1);
      step(1'b1, 8'h45, 8'h38, 1'b0, "w45p38");
      check_val("w45p38_s_const", 32'(s2), 32'h83);
      check_val("w45p38_co_const", 32'(co2), 32'h0);
      // Hold
      held_s1 = e_s1;
      step(1'b0, 8'h77, 8'h77, 1'b1, "hold");
      check_val("hold_ov_const", 32'(ov1), 32'h0);
      check_val("hold_s_const", 32'(s1), 32'(held_s1));
      // Asynchronous reset mid-cycle
      step(1'b1, 8'h57, 8'h68, 1'b1, "pre_rst");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 8'h12, 8'h34, 1'b0, "post_rst");

      // Randomised traffic
      for (int n = 0; n < 400; n++) begin
         ra = {rand_digit(), rand_digit()};
         rb = {rand_digit(), rand_digit()};
         step(($urandom_range(3, 0) != 0), ra, rb, 1'($urandom_range(1, 0)), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
